// File: rtl/iob_mem_responder_if.sv
// IOB request/response bundle between the frontend initiator and the
// data-memory responder. The master drives the request and the slave drives
// the completion.
interface iob_mem_if #(
  parameter int FE_ADDR_W = 32,
  parameter int FE_DATA_W = 32
) ();

  logic                   iob_valid_i;
  logic [FE_ADDR_W-1:0]   iob_addr_i;
  logic [FE_DATA_W-1:0]   iob_wdata_i;
  logic [FE_DATA_W/8-1:0] iob_wstrb_i;
  logic                   iob_ready_o;
  logic [FE_DATA_W-1:0]   iob_rdata_o;

  modport master (
    output iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    input  iob_ready_o, iob_rdata_o
  );

  modport slave (
    input  iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    output iob_ready_o, iob_rdata_o
  );

endinterface

// File: rtl/iob_mem_responder.sv
// IOB responder for the CPU data memory: a word-addressed synchronous RAM
// with byte-strobed writes and a programmable number of wait states before
// each one-cycle ready pulse.
// Optional feature: define IOB_MEM_STATS_EN to add the read/write
// transaction counters rd_count_o and wr_count_o.
module iob_mem_responder #(
  parameter int FE_ADDR_W  = 32,
  parameter int FE_DATA_W  = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  iob_mem_if.slave    bus,
  output logic        busy_o
`ifdef IOB_MEM_STATS_EN
  ,
  output logic [31:0] rd_count_o,
  output logic [31:0] wr_count_o
`endif
);

  localparam int STRB_W = FE_DATA_W / 8;
  localparam int DEPTH  = 1 << MEM_ADDR_W;
  // WAIT runs LATENCY-1 more cycles after the accept cycle; unused when LATENCY=0.
  localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_COOL
  } state_t;

  state_t state, state_nxt;

  logic [3:0]            cnt;
  logic [FE_ADDR_W-1:0]  cap_addr;
  logic [FE_DATA_W-1:0]  cap_wdata;
  logic [STRB_W-1:0]     cap_wstrb;
  logic [FE_DATA_W-1:0]  rdata;

  logic                  accept;
  logic                  enter_resp;
  logic [FE_ADDR_W-1:0]  req_addr;
  logic [FE_DATA_W-1:0]  req_wdata;
  logic [STRB_W-1:0]     req_wstrb;
  logic                  req_write;
  logic                  req_in_range;
  logic [MEM_ADDR_W-1:0] req_idx;

  logic [FE_DATA_W-1:0]  mem [DEPTH];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic plus the accept / RESP-entry strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_nxt  = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.iob_valid_i) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_COOL;
      S_COOL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero latency RESP is entered straight from IDLE, so the live bus
  // request is used; in every other case the captured copy is.
  assign req_addr     = (state == S_IDLE) ? bus.iob_addr_i  : cap_addr;
  assign req_wdata    = (state == S_IDLE) ? bus.iob_wdata_i : cap_wdata;
  assign req_wstrb    = (state == S_IDLE) ? bus.iob_wstrb_i : cap_wstrb;
  assign req_write    = |req_wstrb;
  assign req_in_range = (req_addr >> (MEM_ADDR_W + 2)) == '0;
  assign req_idx      = req_addr[MEM_ADDR_W+1:2];

  // Request capture and wait-state counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      cnt       <= 4'd0;
    end else if (accept) begin
      cap_addr  <= bus.iob_addr_i;
      cap_wdata <= bus.iob_wdata_i;
      cap_wstrb <= bus.iob_wstrb_i;
      cnt       <= CNT_LOAD;
    end else if (state == S_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Byte-lane RAM write on RESP entry; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately not reset so it maps onto block RAM
    // and keeps its contents across reset.
    if (enter_resp && req_write && req_in_range && !reset) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (req_wstrb[i]) mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Read data register: loaded on RESP entry of a read, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (enter_resp && !req_write) begin
      rdata <= req_in_range ? mem[req_idx] : '0;
    end
  end

  assign bus.iob_ready_o = (state == S_RESP);
  assign bus.iob_rdata_o = rdata;
  assign busy_o          = (state != S_IDLE);

`ifdef IOB_MEM_STATS_EN
  // Transaction counters, bumped in the RESP cycle and wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count_o <= 32'd0;
      wr_count_o <= 32'd0;
    end else if (state == S_RESP) begin
      if (|cap_wstrb) wr_count_o <= wr_count_o + 32'd1;
      else            rd_count_o <= rd_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iob_mem_responder.sv
// Self-checking bench for iob_mem_responder: one instance with LATENCY=2 and
// one with LATENCY=0, driven as an IOB initiator, with a queue of expected
// read data and a word model of each RAM.
module tb_iob_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid0, valid2;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        busy0, busy2;

  int          n_vec = 0;
  int          n_err = 0;
  int          pulses0 = 0;
  int          pulses2 = 0;
  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd [2];
  int          exp_rd [2];
  int          exp_wr [2];

  always #5 clk = ~clk;

  iob_mem_if #(.FE_ADDR_W(32), .FE_DATA_W(32)) bus0 ();
  iob_mem_if #(.FE_ADDR_W(32), .FE_DATA_W(32)) bus2 ();

  assign bus0.iob_valid_i = valid0;
  assign bus0.iob_addr_i  = addr;
  assign bus0.iob_wdata_i = wdata;
  assign bus0.iob_wstrb_i = wstrb;
  assign bus2.iob_valid_i = valid2;
  assign bus2.iob_addr_i  = addr;
  assign bus2.iob_wdata_i = wdata;
  assign bus2.iob_wstrb_i = wstrb;

`ifdef IOB_MEM_STATS_EN
  logic [31:0] rd_cnt0, wr_cnt0, rd_cnt2, wr_cnt2;
`endif

  iob_mem_responder #(.FE_ADDR_W(32), .FE_DATA_W(32), .MEM_ADDR_W(10), .LATENCY(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus0),
    .busy_o     (busy0)
`ifdef IOB_MEM_STATS_EN
    ,
    .rd_count_o (rd_cnt0),
    .wr_count_o (wr_cnt0)
`endif
  );

  iob_mem_responder #(.FE_ADDR_W(32), .FE_DATA_W(32), .MEM_ADDR_W(10), .LATENCY(2)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus2),
    .busy_o     (busy2)
`ifdef IOB_MEM_STATS_EN
    ,
    .rd_count_o (rd_cnt2),
    .wr_count_o (wr_cnt2)
`endif
  );

  // Count ready pulses per instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus0.iob_ready_o) pulses0++;
    if (bus2.iob_ready_o) pulses2++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus0.iob_ready_o : bus2.iob_ready_o;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 0) ? busy0 : busy2;
  endfunction

  function automatic logic [31:0] rdat(input int sel);
    return (sel == 0) ? bus0.iob_rdata_o : bus2.iob_rdata_o;
  endfunction

  // One IOB transaction on instance sel (0: LATENCY=0, 1: LATENCY=2).
  // Valid is held through the COOL cycle after ready and dropped in IDLE.
  task automatic txn(input int sel, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws);
    int          cycles;
    bit          got;
    bit          inr;
    int          key;
    logic [31:0] m;
    logic [31:0] exp;
    inr = (a >> 12) == 0;
    key = sel * 4096 + int'(a[11:2]);
    @(negedge clk);
    addr  = a;
    wdata = wd;
    wstrb = ws;
    if (sel == 0) valid0 = 1'b1;
    else          valid2 = 1'b1;
    if (ws == 4'd0) begin
      exp_q.push_back((inr && model.exists(key)) ? model[key] : 32'd0);
      exp_rd[sel]++;
    end else begin
      if (inr) begin
        m = model.exists(key) ? model[key] : 32'd0;
        for (int i = 0; i < 4; i++) if (ws[i]) m[8*i +: 8] = wd[8*i +: 8];
        model[key] = m;
      end
      exp_wr[sel]++;
    end
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) check("busy", 32'(bsy(sel)), 32'd1);
      if (rdy(sel)) got = 1'b1;
    end
    check("latency", cycles, (sel == 0) ? 32'd1 : 32'd3);
    if (ws == 4'd0) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
      if (got) check("rdata", rdat(sel), exp);
      last_rd[sel] = exp;
    end else begin
      check("rdata_hold", rdat(sel), last_rd[sel]);
    end
    @(posedge clk);
    #1;
    check("ready_pulse", 32'(rdy(sel)), 32'd0);
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    valid2 = 1'b0;
  endtask

  task automatic clear_model_state();
    for (int s = 0; s < 2; s++) begin
      last_rd[s] = 32'd0;
      exp_rd[s]  = 0;
      exp_wr[s]  = 0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p;
    logic [31:0] w;
    logic [31:0] d1, d2;
    logic [3:0]  s;

    valid0 = 1'b0;
    valid2 = 1'b0;
    addr   = '0;
    wdata  = '0;
    wstrb  = '0;
    reset  = 1'b1;
    clear_model_state();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready2", 32'(bus2.iob_ready_o), 32'd0);
    check("rst_rdata2", bus2.iob_rdata_o, 32'd0);
    check("rst_busy2",  32'(busy2), 32'd0);
    check("rst_ready0", 32'(bus0.iob_ready_o), 32'd0);
    check("rst_busy0",  32'(busy0), 32'd0);
`ifdef IOB_MEM_STATS_EN
    check("rst_rd_cnt", rd_cnt2, 32'd0);
    check("rst_wr_cnt", wr_cnt2, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Basic write then read, plus ignored low address bits.
    txn(1, 32'h10, 32'hDEADBEEF, 4'hF);
    txn(1, 32'h10, 32'h0, 4'h0);
    txn(1, 32'h13, 32'h0, 4'h0);

    // Byte strobes.
    txn(1, 32'h20, 32'h11223344, 4'hF);
    txn(1, 32'h20, 32'hAABBCCDD, 4'b0101);
    txn(1, 32'h20, 32'h0, 4'h0);
    check("strobe_word", bus2.iob_rdata_o, 32'h11BB33DD);

    // Out-of-range access leaves word 0 alone and reads back zero.
    txn(1, 32'h0, 32'h01020304, 4'hF);
    txn(1, 32'h1000, 32'h5A5A5A5A, 4'hF);
    txn(1, 32'h1000, 32'h0, 4'h0);
    txn(1, 32'h0, 32'h0, 4'h0);

    // Random full write, partial overwrite, read back.
    for (int k = 0; k < 6; k++) begin
      w  = 32'($urandom_range(64, 127)) << 2;
      d1 = $urandom;
      d2 = $urandom;
      s  = 4'($urandom_range(1, 15));
      txn(1, w, d1, 4'hF);
      txn(1, w, d2, s);
      txn(1, w, 32'h0, 4'h0);
    end

    txn(1, 32'h30, 32'h12345678, 4'hF);
`ifdef IOB_MEM_STATS_EN
    check("rd_cnt", rd_cnt2, 32'(exp_rd[1]));
    check("wr_cnt", wr_cnt2, 32'(exp_wr[1]));
`endif

    // Reset during WAIT of a write: aborted, no ready, contents kept.
    @(negedge clk);
    addr   = 32'h30;
    wdata  = 32'hCAFEF00D;
    wstrb  = 4'hF;
    valid2 = 1'b1;
    @(posedge clk);
    #1;
    check("mid_busy", 32'(busy2), 32'd1);
    p = pulses2;
    reset = 1'b1;
    #1;
    check("mid_ready", 32'(bus2.iob_ready_o), 32'd0);
    check("mid_rdata", bus2.iob_rdata_o, 32'd0);
    check("mid_busy_rst", 32'(busy2), 32'd0);
    valid2 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model_state();
`ifdef IOB_MEM_STATS_EN
    check("rst2_rd_cnt", rd_cnt2, 32'd0);
    check("rst2_wr_cnt", wr_cnt2, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_pulse", 32'(pulses2 - p), 32'd0);
    txn(1, 32'h30, 32'h0, 4'h0);

    // Zero-latency instance: back-to-back reads with valid held into COOL.
    txn(0, 32'h0, 32'h0000AAAA, 4'hF);
    txn(0, 32'h4, 32'h5555BBBB, 4'hF);
    p = pulses0;
    txn(0, 32'h0, 32'h0, 4'h0);
    txn(0, 32'h4, 32'h0, 4'h0);
    repeat (4) @(posedge clk);
    #1;
    check("lat0_pulses", 32'(pulses0 - p), 32'd2);
`ifdef IOB_MEM_STATS_EN
    check("lat0_rd_cnt", rd_cnt0, 32'(exp_rd[0]));
    check("lat0_wr_cnt", wr_cnt0, 32'(exp_wr[0]));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
